// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the 4:1 round-robin burst scheduler.
package mux_sched_pkg;

   localparam int N_REQ = 4;  // number of requesters / mux inputs
   localparam int SEL_W = 2;  // width of a requester index
   localparam int CNT_W = 4;  // width of the per-grant beat counter

   // The scheduler is either waiting for requests or streaming one source.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // One-hot grant vector for a requester index.
   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick.sv
// Round-robin winner search: starts one past the last served index and
// ascends with wrap, so the last served requester has the lowest priority.
module rr_pick
   import mux_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] winner_o,
   output logic             found_o
);

   logic [SEL_W-1:0] idx;

   // Scan ptr+1, ptr+2, ... ptr+N_REQ; the first asserted request wins.
   // Wrap-around comes for free from the SEL_W-bit add since N_REQ == 2**SEL_W.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      winner_o = ptr_i;
      found_o  = 1'b0;
      idx      = ptr_i;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ptr_i + SEL_W'(k);
         if (!found_o && req_i[idx]) begin
            winner_o = idx;
            found_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// 4:1 mux scheduler: round-robin grant of up to MAX_BURST beats per
// requester, with zero-bubble hand-over when other requests are pending.
module mux4_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4  // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] last,
   input  logic             out_ready,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             out_valid,
   output logic             busy
);

   state_e           state_q;
   logic [SEL_W-1:0] sel_q;
   logic [N_REQ-1:0] gnt_q;
   logic [SEL_W-1:0] ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic             cur_req;
   logic             cur_last;
   logic             valid_int;
   logic             beat;
   logic             burst_done;
   logic             rel_grant;
   logic [SEL_W-1:0] arb_ptr;
   logic [SEL_W-1:0] winner;
   logic             found;

   // Beat detection and release decision for the currently granted source.
   always_comb begin
      cur_req    = req[sel_q];
      cur_last   = last[sel_q];
      valid_int  = (state_q == GRANT) && cur_req;
      beat       = valid_int && out_ready;
      cnt_d      = cnt_q + CNT_W'(beat);
      // A last beat that also fills the burst is still a single release.
      burst_done = beat && (cur_last || (cnt_d == CNT_W'(MAX_BURST)));
      rel_grant  = (state_q == GRANT) && (!cur_req || burst_done);
      // On release the pointer is about to load sel, so arbitrate from sel now
      // to hand over in the same cycle.
      arb_ptr    = (state_q == GRANT) ? sel_q : ptr_q;
   end

   rr_pick u_rr_pick (
      .req_i    (req),
      .ptr_i    (arb_ptr),
      .winner_o (winner),
      .found_o  (found)
   );

   // Scheduler FSM: grant, count beats, release and re-arbitrate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         ptr_q   <= SEL_W'(N_REQ - 1);  // requester 0 wins the first arbitration
         cnt_q   <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values, independent of statement order.
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q <= GRANT;
                  sel_q   <= winner;
                  gnt_q   <= onehot(winner);
                  cnt_q   <= '0;
               end
            end
            GRANT: begin
               if (rel_grant) begin
                  ptr_q <= sel_q;
                  cnt_q <= '0;
                  if (found) begin
                     sel_q <= winner;
                     gnt_q <= onehot(winner);
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign out_valid = valid_int;
   assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: directed table, corner sequences
// and random traffic against a behavioural model (two burst lengths).
module tb_mux4_rr_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic       out_ready;

   logic [1:0] sel_a, sel_b;
   logic [3:0] gnt_a, gnt_b;
   logic       ov_a, ov_b, busy_a, busy_b;

   int checks = 0;
   int errors = 0;
   int beats_b1 = 0;

   always #5 clk = ~clk;

   mux4_rr_sched #(.MAX_BURST(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
      .sel(sel_a), .gnt(gnt_a), .out_valid(ov_a), .busy(busy_a)
   );

   mux4_rr_sched #(.MAX_BURST(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
      .sel(sel_b), .gnt(gnt_b), .out_valid(ov_b), .busy(busy_b)
   );

   // Behavioural model: who owns the mux, how many beats so far, who was last served.
   typedef struct {
      bit busy;
      int sel;
      int ptr;
      int cnt;
   } model_t;

   model_t m_a, m_b;

   typedef struct {
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic       exp_ov;
      logic [1:0] exp_sel;
      logic [3:0] exp_gnt;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic model_t model_reset();
      model_t m;
      m.busy = 0;
      m.sel  = 0;
      m.ptr  = 3;
      m.cnt  = 0;
      return m;
   endfunction

   function automatic model_t model_next(input model_t m, input int max_burst,
                                         input logic [3:0] r, input logic [3:0] l,
                                         input logic rdy);
      model_t n = m;
      bit rel = 0;
      bit got = 0;
      if (m.busy) begin
         if (!r[m.sel]) rel = 1;
         else if (rdy) begin
            n.cnt = m.cnt + 1;
            if (l[m.sel] || n.cnt == max_burst) rel = 1;
         end
         if (rel) begin
            n.ptr  = m.sel;
            n.busy = 0;
         end
      end
      if (!m.busy || rel) begin
         for (int k = 1; k <= 4; k++) begin
            int idx = (n.ptr + k) % 4;
            if (!got && r[idx]) begin
               got    = 1;
               n.busy = 1;
               n.sel  = idx;
               n.cnt  = 0;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [3:0] exp_gnt(input model_t m);
      return m.busy ? (4'b0001 << m.sel) : 4'b0000;
   endfunction

   task automatic cmp_regs(input string tag);
      check({tag, " sel_a"},  sel_a,  m_a.sel[1:0]);
      check({tag, " gnt_a"},  gnt_a,  exp_gnt(m_a));
      check({tag, " busy_a"}, busy_a, m_a.busy);
      check({tag, " sel_b"},  sel_b,  m_b.sel[1:0]);
      check({tag, " gnt_b"},  gnt_b,  exp_gnt(m_b));
      check({tag, " busy_b"}, busy_b, m_b.busy);
   endtask

   // One clock: drive inputs, check out_valid before the edge, advance models,
   // check registered outputs just after the edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                        input string tag, output logic ov_seen);
      req = r; last = l; out_ready = rdy;
      #1;
      ov_seen = ov_a;
      check({tag, " ov_a"}, ov_a, m_a.busy && r[m_a.sel]);
      check({tag, " ov_b"}, ov_b, m_b.busy && r[m_b.sel]);
      if (ov_b && rdy && sel_b == 2'd1) beats_b1++;
      m_a = model_next(m_a, 4, r, l, rdy);
      m_b = model_next(m_b, 2, r, l, rdy);
      @(posedge clk);
      #1;
      cmp_regs(tag);
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, " rst gnt_a"},  gnt_a,  4'b0000);
      check({tag, " rst busy_a"}, busy_a, 1'b0);
      check({tag, " rst ov_a"},   ov_a,   1'b0);
      check({tag, " rst sel_a"},  sel_a,  2'b00);
      check({tag, " rst gnt_b"},  gnt_b,  4'b0000);
      check({tag, " rst busy_b"}, busy_b, 1'b0);
      m_a = model_reset();
      m_b = model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic ov;
      logic [1:0] rr_seq [5];
      rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
      m_a = model_reset();
      m_b = model_reset();
      @(posedge clk);
      #1;
      do_reset("init");

      // Directed table: single requester burst, abandon hand-over, idle hold.
      vecs.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1});
      vecs.push_back('{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1});
      vecs.push_back('{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1});
      for (int i = 0; i < 10; i++)
         vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].req, vecs[i].last, vecs[i].rdy, $sformatf("vec%0d", i), ov);
         check($sformatf("vec%0d tbl ov", i),   ov,     vecs[i].exp_ov);
         check($sformatf("vec%0d tbl sel", i),  sel_a,  vecs[i].exp_sel);
         check($sformatf("vec%0d tbl gnt", i),  gnt_a,  vecs[i].exp_gnt);
         check($sformatf("vec%0d tbl busy", i), busy_a, vecs[i].exp_busy);
      end

      // All four requesting with last set: one beat each, strict rotation.
      do_reset("rot");
      rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 4'b1111, 1'b1, $sformatf("rot%0d", i), ov);
         check($sformatf("rot%0d sel", i), sel_a, rr_seq[i]);
         check($sformatf("rot%0d busy", i), busy_a, 1'b1);
      end

      // Abandon on index 2 with 1001 pending: ptr becomes 2 so 3 wins.
      do_reset("abn");
      cycle(4'b0100, 4'b0000, 1'b0, "abn0", ov);
      check("abn0 sel", sel_a, 2'd2);
      cycle(4'b0100, 4'b0000, 1'b0, "abn1", ov);
      cycle(4'b1001, 4'b0000, 1'b1, "abn2", ov);
      check("abn2 sel", sel_a, 2'd3);

      // Burst of 2 with gaps in out_ready (checked on the MAX_BURST=2 instance).
      do_reset("bst");
      beats_b1 = 0;
      cycle(4'b0110, 4'b0000, 1'b0, "bst0", ov);
      check("bst0 sel_b", sel_b, 2'd1);
      cycle(4'b0110, 4'b0000, 1'b1, "bst1", ov);
      check("bst1 sel_b", sel_b, 2'd1);
      cycle(4'b0110, 4'b0000, 1'b0, "bst2", ov);
      check("bst2 sel_b", sel_b, 2'd1);
      cycle(4'b0110, 4'b0000, 1'b1, "bst3", ov);
      check("bst3 sel_b", sel_b, 2'd2);
      check("bst beats idx1", beats_b1, 2);

      // Asynchronous reset mid-burst, then first arbitration as after power-up.
      do_reset("mid");
      cycle(4'b0001, 4'b0000, 1'b1, "mid0", ov);
      cycle(4'b0001, 4'b0000, 1'b1, "mid1", ov);
      do_reset("midrst");
      cycle(4'b1000, 4'b0000, 1'b1, "mid2", ov);
      check("mid2 sel", sel_a, 2'd3);
      check("mid2 gnt", gnt_a, 4'b1000);

      // Random traffic against the model.
      do_reset("rnd");
      for (int i = 0; i < 600; i++) begin
         logic [3:0] r, l;
         logic       rdy;
         r   = 4'($urandom);
         l   = 4'($urandom) & 4'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         cycle(r, l, rdy, $sformatf("rnd%0d", i), ov);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
